enid_vram_target: RTL
=====================

Name: enid_vram_target

Overview:
- enid endpoint responder that services remote VRAM requests sent by GPU-side AXI-to-enid bridges.
- Accepts a request header plus write beats on the endpoint request channel.
- Executes word accesses on a local synchronous single-port VRAM.
- Returns a response header plus read beats on the endpoint response channel.
- Sits at module MY_MOD / sub MY_SUB on the enid fabric, directly above the VRAM macro.

Parameters:
- MY_MOD, 4'd1, enid module ID this target answers to (width `ENID_MODULE_ID_W).
- MY_SUB, 2'd0, enid sub ID this target answers to (width `ENID_SUB_ID_W).
- MEM_DATA_W, 24, VRAM word width; must be <= 32.
- MEM_ADDR_W, 16, VRAM word-address width.
- MEM_DEPTH, 65536, valid word count; addresses at or above this are out of range.

Ports:
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request header valid.
- req_ready  out  1  header accepted.
- req_type  in  2  transaction type.
- req_mem_op  in  2  memory operation.
- req_dest_mod  in  `ENID_MODULE_ID_W  destination module.
- req_dest_sub  in  `ENID_SUB_ID_W  destination sub.
- req_addr  in  `ENID_ADDR_W  start word address.
- req_len  in  `ENID_LEN_W  beat count minus 1.
- req_wvalid  in  1  write beat valid.
- req_wready  out  1  write beat accepted.
- req_wdata  in  32  write beat; bits [MEM_DATA_W-1:0] used.
- req_wlast  in  1  final write beat.
- rsp_valid  out  1  response header valid.
- rsp_ready  in  1  header accepted.
- rsp_status  out  2  completion status.
- rsp_len  out  `ENID_LEN_W  beats returned minus 1.
- rsp_rvalid  out  1  read beat valid.
- rsp_rready  in  1  read beat accepted.
- rsp_rdata  out  32  read beat, zero-extended.
- rsp_rlast  out  1  final read beat.
- mem_en  out  1  VRAM access strobe.
- mem_we  out  1  VRAM write.
- mem_addr  out  MEM_ADDR_W  VRAM address.
- mem_wdata  out  MEM_DATA_W  VRAM write data.
- mem_rdata  in  MEM_DATA_W  VRAM read data, valid 1 cycle after mem_en with mem_we=0.

Behaviour:
- Reset (async, rst=1): all outputs 0, FSM in IDLE, beat counters 0, read buffer empty. Reset mid-transfer aborts it and emits no response. VRAM words already written stay written.
- Encodings:
  - type MEM = 2'b00.
  - mem_op READ = 2'b00, WRITE = 2'b01.
  - status OK = 00, DECERR = 01, UNSUP = 10, LENERR = 11.
- States:
  - IDLE: req_ready=1. Header handshake latches all header fields, then goes to DECODE.
  - DECODE: one cycle that computes the error class, in priority order:
    - dest mismatch -> DECERR;
    - type not MEM, or op not READ/WRITE -> UNSUP;
    - addr+len >= MEM_DEPTH, computed at `ENID_ADDR_W+1 bits so there is no wrap -> DECERR.
    - Next state: WDATA for writes (including error writes), RHDR for reads.
  - WDATA: req_wready=1. Each accepted beat:
    - without error: pulse mem_en=mem_we=1 at addr+count, same cycle;
    - with error: beat is discarded, no VRAM access.
    - Exit after the beat where wlast=1 or count==len, whichever comes first. A disagreement between the two sets LENERR unless an earlier error is already set. Next state WRSP.
  - WRSP: rsp_valid=1 with status. rsp_len = len if OK, else 0. Handshake returns to IDLE. No read beats are sent for writes.
  - RHDR: rsp_valid=1. rsp_len = len if OK, else 0.
    - Error: handshake returns to IDLE with no beats.
    - OK: prefetch into the read buffer starts on entry, and handshake moves to RDATA.
  - RDATA: rsp_rvalid = buffer not empty, rsp_rlast on beat len.
    - A read is issued when (occupancy + inflight) < 2 and issued < len+1.
    - Handshake on the last beat returns to IDLE.
- Throughput: with rsp_rready held at 1, one beat per cycle, no bubbles after the first beat. First beat is valid the cycle after the header handshake at the latest.
- Back-pressure: rsp_rready=0 holds rsp_rdata/rsp_rlast stable, and no read is issued that would overflow the buffer.
- Handshake ordering: the header handshake never overlaps a data beat. req_wready=0 outside WDATA. Write data bits [31:MEM_DATA_W] are ignored.
- Concurrency: one request outstanding. req_ready=0 from header acceptance until the response completes.

Decomposition:
- Shared enid defs header holds type/op/status encodings, ENID_* widths, and the state enum.
- Sub-module enid_rd_skid: a 2-entry FIFO for VRAM read data with a registered occupancy count. It presents the count of entries plus inflight reads for the issue decision.

Test Plan:
- Write addr=0x10, len=2, beats A,B,C with wlast on C -> VRAM[0x10..0x12]=A,B,C (low 24 bits); rsp status=00, len=2.
- Read addr=0x10, len=2, rsp_rready=1 -> header 00/len 2, then beats A,B,C on consecutive cycles, rlast on C, upper 8 bits 0.
- Read len=3 with rsp_rready toggling 1,0,0,1... -> no beat lost or duplicated, and data stays stable while stalled.
- dest_mod=2 write, 2 beats -> both beats drained, no mem_we; rsp status=01, len=0. Read with addr=MEM_DEPTH-1, len=1 -> status 01, len=0, no rvalid.
- Write len=3 with wlast on beat 2 -> 2 VRAM writes, status=11. Type=2'b01 -> status 10.
- Assert rst during RDATA beat 1 -> all outputs 0 asynchronously. The next request completes normally.

Source files
------------

// File: rtl/enid_vram_target_pkg.sv
// enid_vram_target_pkg: enid widths, encodings, FSM states and request decode shared by the VRAM target.
package enid_vram_target_pkg;
  localparam int ENID_MODULE_ID_W = 4;
  localparam int ENID_SUB_ID_W = 2;
  localparam int ENID_ADDR_W = 32;
  localparam int ENID_LEN_W = 8;
  localparam logic [1:0] TYPE_MEM = 2'b00;
  localparam logic [1:0] OP_READ = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] ST_OK = 2'b00;
  localparam logic [1:0] ST_DECERR = 2'b01;
  localparam logic [1:0] ST_UNSUP = 2'b10;
  localparam logic [1:0] ST_LENERR = 2'b11;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_WDATA = 3'd2;
  localparam logic [2:0] S_WRSP = 3'd3;
  localparam logic [2:0] S_RHDR = 3'd4;
  localparam logic [2:0] S_RDATA = 3'd5;
  typedef struct packed {
    logic [1:0] typ;
    logic [1:0] op;
    logic [ENID_MODULE_ID_W-1:0] dmod;
    logic [ENID_SUB_ID_W-1:0] dsub;
    logic [ENID_ADDR_W-1:0] addr;
    logic [ENID_LEN_W-1:0] len;
  } hdr_t;
  // The end address is formed one bit wider than the address so a request near the top cannot wrap into range.
  function automatic logic [1:0] decode_status(input hdr_t h, input logic [ENID_MODULE_ID_W-1:0] mod,
                                               input logic [ENID_SUB_ID_W-1:0] sub, input logic [ENID_ADDR_W:0] depth);
    logic [ENID_ADDR_W:0] last;
    last = {1'b0, h.addr} + {{(ENID_ADDR_W+1-ENID_LEN_W){1'b0}}, h.len};
    return (h.dmod != mod || h.dsub != sub) ? ST_DECERR :
           (h.typ != TYPE_MEM || h.op > OP_WRITE) ? ST_UNSUP :
           (last >= depth) ? ST_DECERR : ST_OK;
  endfunction
endpackage

// File: rtl/enid_rd_skid.sv
// enid_rd_skid: 2-entry VRAM read-data FIFO with fall-through of the in-flight word; level counts entries plus in-flight reads.
module enid_rd_skid #(
  parameter int DW = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic          valid,
  output logic [DW-1:0] dout,
  output logic [1:0]    level
);
  logic [DW-1:0] buf_q [2];
  logic [DW-1:0] buf_d [2];
  logic inflight_q, inflight_d, wp_q, wp_d, rp_q, rp_d, push, pop_buf;
  logic [1:0] occ_q, occ_d;
  // When empty the word returning from VRAM is forwarded directly, so a steady stream needs no storage.
  assign pop_buf = pop && occ_q != 2'd0;
  assign push = inflight_q && !(pop && occ_q == 2'd0);
  assign valid = occ_q != 2'd0 || inflight_q;
  assign dout = occ_q != 2'd0 ? buf_q[rp_q] : din;
  assign level = occ_q + {1'b0, inflight_q};
  always_comb begin
    inflight_d = issue;
    occ_d = occ_q + {1'b0, push} - {1'b0, pop_buf};
    wp_d = wp_q ^ push;
    rp_d = rp_q ^ pop_buf;
    buf_d = buf_q;
    if (push) buf_d[wp_q] = din;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q <= '{default: '0};
      inflight_q <= 1'b0;
      occ_q <= 2'd0;
      wp_q <= 1'b0;
      rp_q <= 1'b0;
    end else begin
      buf_q <= buf_d;
      inflight_q <= inflight_d;
      occ_q <= occ_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end
endmodule

// File: rtl/enid_vram_target.sv
// enid_vram_target: enid endpoint that executes remote word reads/writes on a local single-port VRAM.
module enid_vram_target
  import enid_vram_target_pkg::*;
#(
  parameter logic [ENID_MODULE_ID_W-1:0] MY_MOD = 4'd1,
  parameter logic [ENID_SUB_ID_W-1:0]    MY_SUB = 2'd0,
  parameter int MEM_DATA_W = 24,
  parameter int MEM_ADDR_W = 16,
  parameter int MEM_DEPTH = 65536
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [1:0]                  req_type,
  input  logic [1:0]                  req_mem_op,
  input  logic [ENID_MODULE_ID_W-1:0] req_dest_mod,
  input  logic [ENID_SUB_ID_W-1:0]    req_dest_sub,
  input  logic [ENID_ADDR_W-1:0]      req_addr,
  input  logic [ENID_LEN_W-1:0]       req_len,
  input  logic                        req_wvalid,
  output logic                        req_wready,
  input  logic [31:0]                 req_wdata,
  input  logic                        req_wlast,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [1:0]                  rsp_status,
  output logic [ENID_LEN_W-1:0]       rsp_len,
  output logic                        rsp_rvalid,
  input  logic                        rsp_rready,
  output logic [31:0]                 rsp_rdata,
  output logic                        rsp_rlast,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [MEM_ADDR_W-1:0]       mem_addr,
  output logic [MEM_DATA_W-1:0]       mem_wdata,
  input  logic [MEM_DATA_W-1:0]       mem_rdata
);
  localparam logic [ENID_ADDR_W:0] DEPTH = (ENID_ADDR_W+1)'(MEM_DEPTH);
  logic [2:0] state_q, state_d;
  hdr_t hdr_q, hdr_d;
  logic [1:0] status_q, status_d;
  logic [ENID_LEN_W-1:0] cnt_q, cnt_d;
  logic [ENID_LEN_W:0] iss_q, iss_d;
  logic sk_valid, wr_beat, wr_fire, wr_end, rd_issue, rd_state, beat_fire, at_len;
  logic [MEM_DATA_W-1:0] sk_dout;
  logic [1:0] sk_level;
  logic unused_wdata;
  assign unused_wdata = ^req_wdata[31:MEM_DATA_W];
  assign at_len = cnt_q == hdr_q.len;
  assign rd_state = state_q == S_RHDR || state_q == S_RDATA;
  assign wr_beat = state_q == S_WDATA && req_wvalid;
  assign wr_fire = wr_beat && status_q == ST_OK;
  assign wr_end = req_wlast || at_len;
  // Prefetch runs from header presentation onward, bounded so the skid can never overflow.
  assign rd_issue = rd_state && status_q == ST_OK && sk_level < 2'd2 && iss_q <= {1'b0, hdr_q.len};
  assign req_ready = state_q == S_IDLE && !rst;
  assign req_wready = state_q == S_WDATA;
  assign rsp_valid = state_q == S_WRSP || state_q == S_RHDR;
  assign rsp_status = rsp_valid ? status_q : ST_OK;
  assign rsp_len = rsp_valid && status_q == ST_OK ? hdr_q.len : '0;
  assign rsp_rvalid = state_q == S_RDATA && sk_valid;
  assign rsp_rdata = rsp_rvalid ? 32'(sk_dout) : 32'd0;
  assign rsp_rlast = rsp_rvalid && at_len;
  assign beat_fire = rsp_rvalid && rsp_rready;
  assign mem_en = wr_fire || rd_issue;
  assign mem_we = wr_fire;
  assign mem_addr = wr_fire ? MEM_ADDR_W'(hdr_q.addr + ENID_ADDR_W'(cnt_q)) :
                    rd_issue ? MEM_ADDR_W'(hdr_q.addr + ENID_ADDR_W'(iss_q)) : '0;
  assign mem_wdata = wr_fire ? req_wdata[MEM_DATA_W-1:0] : '0;
  enid_rd_skid #(.DW(MEM_DATA_W)) u_skid (
    .clk(clk), .rst(rst), .issue(rd_issue), .din(mem_rdata), .pop(beat_fire),
    .valid(sk_valid), .dout(sk_dout), .level(sk_level)
  );
  always_comb begin
    state_d = state_q;
    hdr_d = hdr_q;
    status_d = status_q;
    cnt_d = cnt_q;
    iss_d = iss_q + {{ENID_LEN_W{1'b0}}, rd_issue};
    case (state_q)
      S_IDLE: if (req_valid) begin
        state_d = S_DECODE;
        hdr_d = '{typ: req_type, op: req_mem_op, dmod: req_dest_mod, dsub: req_dest_sub, addr: req_addr, len: req_len};
        cnt_d = '0;
        iss_d = '0;
      end
      S_DECODE: begin
        status_d = decode_status(hdr_q, MY_MOD, MY_SUB, DEPTH);
        state_d = hdr_q.op == OP_WRITE ? S_WDATA : S_RHDR;
      end
      S_WDATA: if (wr_beat) begin
        cnt_d = cnt_q + ENID_LEN_W'(1);
        if (wr_end) begin
          state_d = S_WRSP;
          if (status_q == ST_OK && req_wlast != at_len) status_d = ST_LENERR;
        end
      end
      S_WRSP: if (rsp_ready) state_d = S_IDLE;
      S_RHDR: if (rsp_ready) state_d = status_q == ST_OK ? S_RDATA : S_IDLE;
      S_RDATA: if (beat_fire) begin
        cnt_d = cnt_q + ENID_LEN_W'(1);
        if (rsp_rlast) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      hdr_q <= '0;
      status_q <= ST_OK;
      cnt_q <= '0;
      iss_q <= '0;
    end else begin
      state_q <= state_d;
      hdr_q <= hdr_d;
      status_q <= status_d;
      cnt_q <= cnt_d;
      iss_q <= iss_d;
    end
  end
endmodule
